muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_div_step.sv | 29 ++
 rtl/muldiv_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - Operation encodings presented on the op input of muldiv_unit.
//   - FSM state encodings used by muldiv_unit.
//   - is_signed_op(): true for the operations that use signed operands.
package muldiv_pkg;

  // Operation encodings
  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  // FSM state type and encodings
  typedef logic [1:0] muldiv_state_t;

  localparam muldiv_state_t StIdle = 2'd0;
  localparam muldiv_state_t StMul  = 2'd1;
  localparam muldiv_state_t StDiv  = 2'd2;
  localparam muldiv_state_t StFix  = 2'd3;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One iteration of a radix-2 restoring divider (purely combinational).
// Ports:
//   rem_i      - partial remainder before this step
//   dvd_bit_i  - next dividend bit shifted into the remainder
//   dsr_i      - divisor magnitude
//   rem_o      - partial remainder after this step
//   quo_bit_o  - quotient bit produced by this step
module muldiv_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quo_bit_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  assign trial = {rem_i, dvd_bit_i};
  assign diff  = trial - {1'b0, dsr_i};

  // No borrow out of the trial subtraction means trial >= divisor.
  assign quo_bit_o = ~diff[WIDTH];
  // The kept remainder is always below the divisor, so it fits in WIDTH bits.
  assign rem_o     = quo_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-high reset
//   start  - issue request (accepted only when idle)
//   op     - operation (muldiv_pkg Op* encodings)
//   a, b   - rs/rt operands (only a is used by MTHI/MTLO)
//   flush  - abort any in-flight operation; wins over start
//   busy   - operation in flight
//   done   - one-cycle pulse after HI/LO has been updated
//   hi, lo - architectural HI/LO registers
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational
// multiplier; otherwise multiplies use a serial shift-add, one bit per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // dvd: dividend/quotient shift register, or multiplier/product low half.
  // rem: partial remainder, or product high half.
  // dsr: divisor magnitude, or multiplicand magnitude.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             qneg_q, qneg_d;  // negate quotient/product
  logic             rneg_q, rneg_d;  // negate remainder (dividend sign)
  logic             dz_q, dz_d;      // divide by zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Operand signs and magnitudes for the request on the inputs
  logic             op_signed;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_signed = is_signed_op(op);
  assign sign_a    = op_signed & a[WIDTH-1];
  assign sign_b    = op_signed & b[WIDTH-1];
  assign mag_a     = sign_a ? -a : a;
  assign mag_b     = sign_b ? -b : b;

  // Divide step
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  muldiv_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .dsr_i     (dsr_q),
    .rem_o     (step_rem),
    .quo_bit_o (step_qbit)
  );

  // Multiply datapath
  logic [2*WIDTH-1:0] mul_raw;
  logic [2*WIDTH-1:0] mul_res;

`ifdef MULDIV_FAST_MUL_EN
  assign mul_raw = {{WIDTH{1'b0}}, dsr_q} * {{WIDTH{1'b0}}, dvd_q};
`else
  // Add the multiplicand into the high half when the current multiplier bit
  // is set, then shift the whole {carry, high, low} right by one.
  logic [WIDTH:0] mul_sum;

  assign mul_sum = {1'b0, rem_q} + (dvd_q[0] ? {1'b0, dsr_q} : {(WIDTH + 1){1'b0}});
  assign mul_raw = {mul_sum, dvd_q[WIDTH-1:1]};
`endif

  assign mul_res = qneg_q ? -mul_raw : mul_raw;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (op)
              OpMthi: begin
                hi_d   = a;
                done_d = 1'b1;
              end
              OpMtlo: begin
                lo_d   = a;
                done_d = 1'b1;
              end
              OpMult, OpMultu: begin
                dsr_d   = mag_a;
                dvd_d   = mag_b;
                rem_d   = '0;
                qneg_d  = sign_a ^ sign_b;
                cnt_d   = CNT_W'(WIDTH - 1);
                state_d = StMul;
              end
              OpDiv, OpDivu: begin
                dsr_d  = mag_b;
                rem_d  = '0;
                qneg_d = sign_a ^ sign_b;
                rneg_d = sign_a;
                if (b == '0) begin
                  // Keep the raw dividend: it becomes HI unchanged.
                  dz_d    = 1'b1;
                  dvd_d   = a;
                  state_d = StFix;
                end else begin
                  dz_d    = 1'b0;
                  dvd_d   = mag_a;
                  cnt_d   = CNT_W'(WIDTH - 1);
                  state_d = StDiv;
                end
              end
              default: ;
            endcase
          end
        end

        StMul: begin
`ifdef MULDIV_FAST_MUL_EN
          {hi_d, lo_d} = mul_res;
          done_d       = 1'b1;
          state_d      = StIdle;
`else
          rem_d = mul_raw[2*WIDTH-1:WIDTH];
          dvd_d = mul_raw[WIDTH-1:0];
          if (cnt_q == '0) begin
            {hi_d, lo_d} = mul_res;
            done_d       = 1'b1;
            state_d      = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
`endif
        end

        StDiv: begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
          if (cnt_q == '0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        StFix: begin
          if (dz_q) begin
            lo_d = '1;
            hi_d = dvd_q;
          end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            lo_d = qneg_q ? -dvd_q : dvd_q;
            hi_d = rneg_q ? -rem_q : rem_q;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32). The driver pushes the expected
// HI/LO and the expected done time for each accepted request; the monitor pops
// and compares on every done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = W + 1;
`endif
  localparam int DivLat = W + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_unit #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    time          due;
    int           id;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   op_id = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no done (t=%0t)",
                 hi, lo, $time);
      end else begin
        mon_e = sbq.pop_front();
        chk($sformatf("op%0d_hi", mon_e.id), 64'(hi), 64'(mon_e.hi));
        chk($sformatf("op%0d_lo", mon_e.id), 64'(lo), 64'(mon_e.lo));
        chk($sformatf("op%0d_done_time", mon_e.id), 64'($time), 64'(mon_e.due));
      end
    end
  end

  // Issue one request; when push is set the expected result is scoreboarded.
  // lat counts edges from the accepting edge up to the cycle done is high.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input int lat,
                       input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    a     = aa;
    b     = bb;
    @(posedge clk);
    op_id++;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.due = $time + time'((lat - 1) * 10 + 5);
      e.id  = op_id;
      sbq.push_back(e);
    end
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Moves
    issue(OpMthi, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 1, 1);
    drain();
    issue(OpMtlo, 32'h0BADF00D, 32'h0, 32'hDEADBEEF, 32'h0BADF00D, 1, 1);
    drain();

    // Divides
    issue(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, DivLat, 1);
    drain();
    issue(OpDiv, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DivLat, 1);
    drain();
    issue(OpDiv, 32'd7, -32'sd2, 32'h1, 32'hFFFFFFFD, DivLat, 1);
    drain();
    issue(OpDiv, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 2, 1);
    drain();
    issue(OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DivLat, 1);
    drain();

    // Multiplies
    issue(OpMult, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, MulLat, 1);
    drain();
    issue(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MulLat, 1);
    drain();
    issue(OpMult, -32'sd4, -32'sd6, 32'h0, 32'h18, MulLat, 1);
    drain();

    // Flush at cycle 10 of a DIVU, with a simultaneous MTHI start
    issue(OpDivu, 32'd1000, 32'd3, 32'h0, 32'h0, DivLat, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    start = 1'b1;
    op    = OpMthi;
    a     = 32'h5555;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_hi", 64'(hi), 64'h0);
    chk("flush_lo", 64'(lo), 64'h18);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_late_busy", 64'(busy), 64'd0);
    chk("flush_late_hi", 64'(hi), 64'h0);
    chk("flush_late_lo", 64'(lo), 64'h18);

    // Start while busy is ignored; HI/LO stay stable until commit
    issue(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, DivLat, 1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    op    = OpMthi;
    a     = 32'hAAAA;
    chk("ignore_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignore_mid_hi", 64'(hi), 64'h0);
    chk("ignore_mid_lo", 64'(lo), 64'h18);
    drain();

    // Reset in the middle of a MULTU
    issue(OpMultu, 32'h10, 32'h10, 32'h0, 32'h0, MulLat, 0);
    repeat (1) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midreset_hi", 64'(hi), 64'd0);
    chk("midreset_lo", 64'(lo), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("postreset_busy", 64'(busy), 64'd0);
    chk("postreset_lo", 64'(lo), 64'd0);

    // Unit works normally after reset
    issue(OpMultu, 32'd7, 32'd6, 32'h0, 32'd42, MulLat, 1);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
